// File: rtl/adder_32b_if.sv
// rtl/adder_32b_if.sv - operand/result bundle for the 32-bit adder/subtractor
//
// Purpose : groups the adder's operand inputs and result outputs so the
//           ALU side (master) and the adder (slave) share one port.
// Signals : A, B      operands
//           SUB       0: A+B, 1: A-B
//           S, COUT   combinational result and carry out of the MSB
//           S_REG, COUT_REG  result and carry registered on rising clk
//           V, Z, N and V_REG, Z_REG, N_REG only with ADDER32B_FLAGS_EN
interface adder_32b_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             SUB;
  logic [WIDTH-1:0] S;
  logic             COUT;
  logic [WIDTH-1:0] S_REG;
  logic             COUT_REG;
`ifdef ADDER32B_FLAGS_EN
  logic             V;
  logic             Z;
  logic             N;
  logic             V_REG;
  logic             Z_REG;
  logic             N_REG;
`endif

  modport master (
    output A, B, SUB,
`ifdef ADDER32B_FLAGS_EN
    input  V, Z, N, V_REG, Z_REG, N_REG,
`endif
    input  S, COUT, S_REG, COUT_REG
  );

  modport slave (
    input  A, B, SUB,
`ifdef ADDER32B_FLAGS_EN
    output V, Z, N, V_REG, Z_REG, N_REG,
`endif
    output S, COUT, S_REG, COUT_REG
  );
endinterface

// File: rtl/adder_32b.sv
// rtl/adder_32b.sv - 32-bit two-level carry-lookahead adder/subtractor
//
// Purpose : {COUT,S} = A + (B ^ {32{SUB}}) + SUB, purely combinational,
//           plus a one-cycle registered copy for pipelined consumers.
// Ports   : clk    core clock, rising edge
//           rst_n  asynchronous active-low reset (clears registered copies only)
//           bus    adder_32b_if.slave (A, B, SUB in; S, COUT, S_REG, COUT_REG out)
// Option  : ADDER32B_FLAGS_EN adds V/Z/N flags and their registered copies.
// WIDTH   : only 32 is supported.
module adder_32b #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  adder_32b_if.slave  bus
);

  localparam int NG = WIDTH / 4;

  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] s_int;
  logic [WIDTH:0]   c;
  logic [NG-1:0]    gg;
  logic [NG-1:0]    gp;
  logic [NG:0]      gc;

  // Subtraction is A + ~B + 1: invert B here, the +1 enters as carry-in.
  assign bx = bus.B ^ {WIDTH{bus.SUB}};
  assign p  = bus.A ^ bx;
  assign g  = bus.A & bx;

  // First level: each 4-bit group exports generate/propagate and expands its
  // own bit carries from the group carry-in supplied by the second level.
  generate
    for (genvar k = 0; k < NG; k++) begin : g_grp
      assign gp[k] = &p[4*k +: 4];
      assign gg[k] = g[4*k+3]
                   | (p[4*k+3] & g[4*k+2])
                   | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                   | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);

      assign c[4*k]   = gc[k];
      assign c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      assign c[4*k+2] = g[4*k+1]
                      | (p[4*k+1] & g[4*k])
                      | (p[4*k+1] & p[4*k] & gc[k]);
      assign c[4*k+3] = g[4*k+2]
                      | (p[4*k+2] & g[4*k+1])
                      | (p[4*k+2] & p[4*k+1] & g[4*k])
                      | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
  endgenerate

  // Second level: every group carry is a flat sum of products over the group
  // generates below it, so no carry waits on another group carry.
  always_comb begin : lookahead
    logic acc;
    logic run;
    acc   = 1'b0;
    run   = 1'b1;
    gc    = '0;
    gc[0] = bus.SUB;
    for (int k = 0; k < NG; k++) begin
      acc = 1'b0;
      run = 1'b1;
      for (int j = k; j >= 0; j--) begin
        acc = acc | (gg[j] & run);
        run = run & gp[j];
      end
      gc[k+1] = acc | (run & bus.SUB);
    end
  end

  assign c[WIDTH] = gc[NG];
  assign s_int    = p ^ c[WIDTH-1:0];

  assign bus.S    = s_int;
  assign bus.COUT = c[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.S_REG    <= '0;
      bus.COUT_REG <= 1'b0;
    end else begin
      bus.S_REG    <= s_int;
      bus.COUT_REG <= c[WIDTH];
    end
  end

`ifdef ADDER32B_FLAGS_EN
  logic v;
  logic z;
  logic n;

  // Overflow: operands (after B inversion) agree in sign but the result does not.
  assign v = (bus.A[WIDTH-1] == bx[WIDTH-1]) && (s_int[WIDTH-1] != bus.A[WIDTH-1]);
  assign z = ~|s_int;
  assign n = s_int[WIDTH-1];

  assign bus.V = v;
  assign bus.Z = z;
  assign bus.N = n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.V_REG <= 1'b0;
      bus.Z_REG <= 1'b0;
      bus.N_REG <= 1'b0;
    end else begin
      bus.V_REG <= v;
      bus.Z_REG <= z;
      bus.N_REG <= n;
    end
  end
`endif

endmodule

// File: tb/tb_adder_32b.sv
// tb/tb_adder_32b.sv - self-checking bench for adder_32b
module tb_adder_32b;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  adder_32b_if #(.WIDTH(32)) bus ();

  adder_32b #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] s;
    logic        c;
  } vec_t;

  // Reference: plain arithmetic on the operands' numeric values.
  function automatic void ref_model(input logic [31:0] a, input logic [31:0] b,
                                    input logic sub, output logic [31:0] s,
                                    output logic c, output logic v);
    logic [32:0] w;
    longint      sr;
    if (!sub) begin
      w  = {1'b0, a} + {1'b0, b};
      s  = w[31:0];
      c  = w[32];
      sr = longint'($signed(a)) + longint'($signed(b));
    end else begin
      s  = a - b;
      c  = (a >= b);
      sr = longint'($signed(a)) - longint'($signed(b));
    end
    v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic sub);
    bus.A   = a;
    bus.B   = b;
    bus.SUB = sub;
  endtask

  task automatic test_reset();
    logic [31:0] es;
    logic ec, ev;
    rst_n = 1'b0;
    drive(32'h0000_1234, 32'h0000_4321, 1'b0);
    #5;
    n_checks++;
    if (bus.S_REG !== 32'h0 || bus.COUT_REG !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_initial: S_REG=%h COUT_REG=%b, expected 0/0", bus.S_REG, bus.COUT_REG);
    end
    repeat (2) @(posedge clk);
    #1;
    ref_model(bus.A, bus.B, bus.SUB, es, ec, ev);
    n_checks++;
    if (bus.S_REG !== 32'h0 || bus.COUT_REG !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_held: S_REG=%h COUT_REG=%b, expected 0/0", bus.S_REG, bus.COUT_REG);
    end
    n_checks++;
    if (bus.S !== es || bus.COUT !== ec) begin
      n_fail++;
      $display("FAIL reset_comb_live: S=%h COUT=%b, expected %h/%b", bus.S, bus.COUT, es, ec);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.S_REG !== 32'h0000_5555 || bus.COUT_REG !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first_capture: S_REG=%h COUT_REG=%b, expected 00005555/0", bus.S_REG, bus.COUT_REG);
    end
  endtask

  task automatic test_sweep(input logic sub);
    logic [31:0] es;
    logic ec, ev;
    int errs;
    errs = 0;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        drive(32'(a), 32'(b), sub);
        #10;
        ref_model(32'(a), 32'(b), sub, es, ec, ev);
        n_checks++;
        if (bus.S !== es || bus.COUT !== ec) begin
          n_fail++;
          errs++;
          if (errs <= 10)
            $display("FAIL sweep sub=%b A=%h B=%h: S=%h COUT=%b, expected %h/%b",
                     sub, a, b, bus.S, bus.COUT, es, ec);
        end
      end
    end
  endtask

  task automatic test_boundaries();
    vec_t tbl [10];
    tbl = '{
      '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1},
      '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1},
      '{32'h0000_0005, 32'h0000_0003, 1'b1, 32'h0000_0002, 1'b1},
      '{32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0},
      '{32'h9ABC_DEF0, 32'h9ABC_DEF0, 1'b1, 32'h0000_0000, 1'b1},
      '{32'hCAFE_BABE, 32'h0000_0000, 1'b1, 32'hCAFE_BABE, 1'b1},
      '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1},
      '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b1},
      '{32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0},
      '{32'h0000_00FF, 32'h0000_00FF, 1'b0, 32'h0000_01FE, 1'b0}
    };
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].a, tbl[i].b, tbl[i].sub);
      #10;
      n_checks++;
      if (bus.S !== tbl[i].s || bus.COUT !== tbl[i].c) begin
        n_fail++;
        $display("FAIL boundary[%0d] A=%h B=%h SUB=%b: S=%h COUT=%b, expected %h/%b",
                 i, tbl[i].a, tbl[i].b, tbl[i].sub, bus.S, bus.COUT, tbl[i].s, tbl[i].c);
      end
    end
  endtask

  task automatic test_registered();
    @(negedge clk);
    drive(32'h0000_0001, 32'h0000_0002, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(32'h1234_5678, 32'h1111_1111, 1'b0);
    #10;
    n_checks++;
    if (bus.S_REG !== 32'h0000_0003 || bus.COUT_REG !== 1'b0) begin
      n_fail++;
      $display("FAIL reg_hold: S_REG=%h COUT_REG=%b, expected 00000003/0", bus.S_REG, bus.COUT_REG);
    end
    n_checks++;
    if (bus.S !== 32'h2345_6789) begin
      n_fail++;
      $display("FAIL reg_comb: S=%h, expected 23456789", bus.S);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.S_REG !== 32'h2345_6789 || bus.COUT_REG !== 1'b0) begin
      n_fail++;
      $display("FAIL reg_capture: S_REG=%h COUT_REG=%b, expected 23456789/0", bus.S_REG, bus.COUT_REG);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, es, prev_s;
    logic sub, ec, ev, prev_c;
    logic [31:0] corner [4];
    corner[0] = 32'h0000_0000;
    corner[1] = 32'hFFFF_FFFF;
    corner[2] = 32'h8000_0000;
    corner[3] = 32'h7FFF_FFFF;
    prev_s = bus.S_REG;
    prev_c = bus.COUT_REG;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      a   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      b   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      sub = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) b = a;
      drive(a, b, sub);
      #10;
      ref_model(a, b, sub, es, ec, ev);
      n_checks++;
      if (bus.S !== es || bus.COUT !== ec) begin
        n_fail++;
        $display("FAIL rand_comb A=%h B=%h SUB=%b: S=%h COUT=%b, expected %h/%b",
                 a, b, sub, bus.S, bus.COUT, es, ec);
      end
      n_checks++;
      if (bus.S_REG !== prev_s || bus.COUT_REG !== prev_c) begin
        n_fail++;
        $display("FAIL rand_reg_hold: S_REG=%h COUT_REG=%b, expected %h/%b",
                 bus.S_REG, bus.COUT_REG, prev_s, prev_c);
      end
`ifdef ADDER32B_FLAGS_EN
      n_checks++;
      if (bus.V !== ev || bus.Z !== (es == 32'h0) || bus.N !== es[31]) begin
        n_fail++;
        $display("FAIL rand_flags A=%h B=%h SUB=%b: VZN=%b%b%b, expected %b%b%b",
                 a, b, sub, bus.V, bus.Z, bus.N, ev, (es == 32'h0), es[31]);
      end
`endif
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.S_REG !== es || bus.COUT_REG !== ec) begin
        n_fail++;
        $display("FAIL rand_reg_capture A=%h B=%h SUB=%b: S_REG=%h COUT_REG=%b, expected %h/%b",
                 a, b, sub, bus.S_REG, bus.COUT_REG, es, ec);
      end
      prev_s = es;
      prev_c = ec;
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] es;
    logic ec, ev;
    @(negedge clk);
    drive(32'hDEAD_BEEF, 32'h0000_0001, 1'b0);
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.S_REG !== 32'hDEAD_BEF0 || bus.COUT_REG !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_pre: S_REG=%h COUT_REG=%b, expected deadbef0/0", bus.S_REG, bus.COUT_REG);
    end
    #20;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.S_REG !== 32'h0 || bus.COUT_REG !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_immediate: S_REG=%h COUT_REG=%b, expected 0/0", bus.S_REG, bus.COUT_REG);
    end
    n_checks++;
    if (bus.S !== 32'hDEAD_BEF0 || bus.COUT !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_comb_live: S=%h COUT=%b, expected deadbef0/0", bus.S, bus.COUT);
    end
    drive(32'hF000_0000, 32'h2000_0000, 1'b0);
    #10;
    ref_model(32'hF000_0000, 32'h2000_0000, 1'b0, es, ec, ev);
    n_checks++;
    if (bus.S !== es || bus.COUT !== ec) begin
      n_fail++;
      $display("FAIL arst_comb_change: S=%h COUT=%b, expected %h/%b", bus.S, bus.COUT, es, ec);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.S_REG !== 32'h0 || bus.COUT_REG !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_held: S_REG=%h COUT_REG=%b, expected 0/0", bus.S_REG, bus.COUT_REG);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #10;
    n_checks++;
    if (bus.S_REG !== 32'h0) begin
      n_fail++;
      $display("FAIL arst_release_no_capture: S_REG=%h, expected 0", bus.S_REG);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.S_REG !== es || bus.COUT_REG !== ec) begin
      n_fail++;
      $display("FAIL arst_release_capture: S_REG=%h COUT_REG=%b, expected %h/%b",
               bus.S_REG, bus.COUT_REG, es, ec);
    end
  endtask

`ifdef ADDER32B_FLAGS_EN
  task automatic test_flags();
    @(negedge clk);
    drive(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    #10;
    n_checks++;
    if (bus.V !== 1'b1 || bus.N !== 1'b1 || bus.Z !== 1'b0) begin
      n_fail++;
      $display("FAIL flags_pos_ovf: VZN=%b%b%b, expected 101", bus.V, bus.Z, bus.N);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.V_REG !== 1'b1 || bus.N_REG !== 1'b1 || bus.Z_REG !== 1'b0) begin
      n_fail++;
      $display("FAIL flags_reg_ovf: VZN_REG=%b%b%b, expected 101", bus.V_REG, bus.Z_REG, bus.N_REG);
    end
    @(negedge clk);
    drive(32'h0000_0007, 32'h0000_0007, 1'b1);
    #10;
    n_checks++;
    if (bus.Z !== 1'b1 || bus.V !== 1'b0 || bus.N !== 1'b0) begin
      n_fail++;
      $display("FAIL flags_zero: VZN=%b%b%b, expected 010", bus.V, bus.Z, bus.N);
    end
    drive(32'h8000_0000, 32'h8000_0000, 1'b0);
    #10;
    n_checks++;
    if (bus.V !== 1'b1 || bus.Z !== 1'b1 || bus.N !== 1'b0) begin
      n_fail++;
      $display("FAIL flags_neg_ovf: VZN=%b%b%b, expected 110", bus.V, bus.Z, bus.N);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.V_REG !== 1'b1 || bus.Z_REG !== 1'b1 || bus.N_REG !== 1'b0) begin
      n_fail++;
      $display("FAIL flags_reg_neg_ovf: VZN_REG=%b%b%b, expected 110", bus.V_REG, bus.Z_REG, bus.N_REG);
    end
    #20;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.V_REG !== 1'b0 || bus.Z_REG !== 1'b0 || bus.N_REG !== 1'b0) begin
      n_fail++;
      $display("FAIL flags_reg_reset: VZN_REG=%b%b%b, expected 000", bus.V_REG, bus.Z_REG, bus.N_REG);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_sweep(1'b0);
    test_sweep(1'b1);
    test_boundaries();
    test_registered();
    test_back_to_back();
    test_async_reset();
`ifdef ADDER32B_FLAGS_EN
    test_flags();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
